// File: rtl/multi_channel_debouncer.sv
// N-channel debouncer: 2-flop synchroniser, per-channel counter and a two-state FSM
// (early-detect lockout or delayed stability-confirm). Edge pulses need DEBOUNCE_EDGE_PULSE_EN.
module multi_channel_debouncer #(
  parameter int N_CH         = 4,
  parameter int DELAY_CYCLES = 20000000,
  parameter int EARLY_MODE   = 1,
  parameter bit RESET_LEVEL  = 1'b0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N_CH-1:0] noisy,
  output logic [N_CH-1:0] debounced,
  output logic [N_CH-1:0] rise_pulse,
  output logic [N_CH-1:0] fall_pulse
);

  localparam int CNT_W = $clog2(DELAY_CYCLES + 1);

  localparam logic [0:0] ST_STABLE  = 1'b0;
  localparam logic [0:0] ST_LOCKOUT = 1'b1;
  localparam logic [0:0] ST_PENDING = 1'b1;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DELAY_CYCLES);

  logic [N_CH-1:0]            sync_meta;
  logic [N_CH-1:0]            sync_q;
  logic [N_CH-1:0]            deb_q;
  logic [N_CH-1:0]            deb_d;
  // One state bit per channel; kept as a named vector so checkers can bind to it.
  logic [N_CH-1:0]            state_q;
  logic [N_CH-1:0]            state_d;
  logic [N_CH-1:0][CNT_W-1:0] cnt_q;
  logic [N_CH-1:0][CNT_W-1:0] cnt_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta <= {N_CH{RESET_LEVEL}};
      sync_q    <= {N_CH{RESET_LEVEL}};
    end else begin
      sync_meta <= noisy;
      sync_q    <= sync_meta;
    end
  end

  always_comb begin
    deb_d   = deb_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < N_CH; i++) begin
      if (EARLY_MODE != 0) begin
        // Early-detect: follow the input at once, then ignore it for DELAY_CYCLES.
        if (state_q[i] == ST_STABLE) begin
          if (sync_q[i] != deb_q[i]) begin
            deb_d[i]   = sync_q[i];
            cnt_d[i]   = '0;
            state_d[i] = ST_LOCKOUT;
          end
        end else if (cnt_q[i] == CNT_LAST) begin
          cnt_d[i]   = '0;
          state_d[i] = ST_STABLE;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end else begin
        // Delayed: accept a new level only after it persists DELAY_CYCLES+1 samples.
        if (state_q[i] == ST_STABLE) begin
          if (sync_q[i] != deb_q[i]) begin
            cnt_d[i]   = CNT_ONE;
            state_d[i] = ST_PENDING;
          end
        end else if (sync_q[i] == deb_q[i]) begin
          cnt_d[i]   = '0;
          state_d[i] = ST_STABLE;
        end else if (cnt_q[i] == CNT_MAX) begin
          deb_d[i]   = sync_q[i];
          cnt_d[i]   = '0;
          state_d[i] = ST_STABLE;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_q   <= {N_CH{RESET_LEVEL}};
      state_q <= {N_CH{ST_STABLE}};
      cnt_q   <= '0;
    end else begin
      deb_q   <= deb_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign debounced = deb_q;

`ifdef DEBOUNCE_EDGE_PULSE_EN
  logic [N_CH-1:0] rise_q;
  logic [N_CH-1:0] fall_q;

  // Registered from the same next-level term so pulses line up with the new level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= deb_d & ~deb_q;
      fall_q <= ~deb_d & deb_q;
    end
  end

  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
`else
  assign rise_pulse = '0;
  assign fall_pulse = '0;
`endif

endmodule

// File: tb/tb_multi_channel_debouncer.sv
// Bench for multi_channel_debouncer: an early-mode and a delayed-mode instance share the
// same inputs and are compared every cycle against an event-timing reference model.
module tb_multi_channel_debouncer;

  localparam int N   = 4;
  localparam int DLY = 8;
`ifdef DEBOUNCE_EDGE_PULSE_EN
  localparam logic PULSE_EN = 1'b1;
`else
  localparam logic PULSE_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [N-1:0] noisy = '0;
  logic [N-1:0] deb_e, rise_e, fall_e;
  logic [N-1:0] deb_dl, rise_dl, fall_dl;
  logic [23:0]  obs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multi_channel_debouncer #(.N_CH(N), .DELAY_CYCLES(DLY), .EARLY_MODE(1), .RESET_LEVEL(1'b0)) dut_early (
    .clk(clk), .reset_n(reset_n), .noisy(noisy),
    .debounced(deb_e), .rise_pulse(rise_e), .fall_pulse(fall_e)
  );

  multi_channel_debouncer #(.N_CH(N), .DELAY_CYCLES(DLY), .EARLY_MODE(0), .RESET_LEVEL(1'b0)) dut_delay (
    .clk(clk), .reset_n(reset_n), .noisy(noisy),
    .debounced(deb_dl), .rise_pulse(rise_dl), .fall_pulse(fall_dl)
  );

  assign obs = {deb_e, rise_e, fall_e, deb_dl, rise_dl, fall_dl};

  // Reference model: inputs become visible two edges late; early mode may change
  // only when more than DLY edges have passed since its last change; delayed mode
  // changes once the visible input has disagreed for DLY+1 consecutive edges.
  logic [N-1:0] hist_q[$];
  logic [N-1:0] m_deb_e, m_rise_e, m_fall_e;
  logic [N-1:0] m_deb_d, m_rise_d, m_fall_d;
  int           since_e[N];
  int           run_d[N];
  logic [23:0]  exp_q[$];

  function automatic logic [23:0] model_vec();
    return {m_deb_e, m_rise_e & {N{PULSE_EN}}, m_fall_e & {N{PULSE_EN}},
            m_deb_d, m_rise_d & {N{PULSE_EN}}, m_fall_d & {N{PULSE_EN}}};
  endfunction

  task automatic model_reset();
    hist_q.delete();
    hist_q.push_back('0);
    hist_q.push_back('0);
    m_deb_e = '0; m_rise_e = '0; m_fall_e = '0;
    m_deb_d = '0; m_rise_d = '0; m_fall_d = '0;
    for (int i = 0; i < N; i++) begin
      since_e[i] = DLY + 1;
      run_d[i]   = 0;
    end
    exp_q.delete();
  endtask

  task automatic step(input logic [N-1:0] val);
    logic [N-1:0] s;
    noisy = val;
    @(posedge clk);
    hist_q.push_back(val);
    s = hist_q[0];
    void'(hist_q.pop_front());
    for (int i = 0; i < N; i++) begin
      m_rise_e[i] = 1'b0; m_fall_e[i] = 1'b0;
      m_rise_d[i] = 1'b0; m_fall_d[i] = 1'b0;
      since_e[i]++;
      if (since_e[i] > DLY && s[i] != m_deb_e[i]) begin
        m_deb_e[i]  = s[i];
        m_rise_e[i] = s[i];
        m_fall_e[i] = ~s[i];
        since_e[i]  = 0;
      end
      if (s[i] != m_deb_d[i]) run_d[i]++;
      else run_d[i] = 0;
      if (run_d[i] == DLY + 1) begin
        m_deb_d[i]  = s[i];
        m_rise_d[i] = s[i];
        m_fall_d[i] = ~s[i];
        run_d[i]    = 0;
      end
    end
    exp_q.push_back(model_vec());
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    noisy   = '0;
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [23:0] exp;
    reset_n = 1'b0;
    noisy   = 4'hF;
    model_reset();
    #1;
    exp = model_vec();
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL reset_async got=%h exp=%h", obs, exp);
    end
    @(posedge clk);
    #1;
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL reset_held got=%h exp=%h", obs, exp);
    end
    reset_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step(4'hF);
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL reset_release cyc=%0d got=%h exp=%h", k, obs, exp);
      end
    end
  endtask

  task automatic test_early_bounce();
    logic [23:0] exp;
    logic [N-1:0] v;
    apply_reset();
    for (int k = 0; k < 24; k++) begin
      v = (k < 6) ? {3'b000, ((k / 2) % 2 == 0)} : 4'h1;
      step(v);
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL early_bounce cyc=%0d got=%h exp=%h", k, obs, exp);
      end
    end
  endtask

  task automatic test_lockout_expiry();
    logic [23:0] exp;
    logic [N-1:0] v;
    apply_reset();
    // Long press, release; then a short press released inside the lockout window.
    for (int k = 0; k < 60; k++) begin
      v = (k < 20 || (k >= 35 && k < 38)) ? 4'h1 : 4'h0;
      step(v);
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL lockout_expiry cyc=%0d got=%h exp=%h", k, obs, exp);
      end
    end
  endtask

  task automatic test_delayed_glitch();
    logic [23:0] exp;
    logic [N-1:0] v;
    apply_reset();
    for (int k = 0; k < 45; k++) begin
      v = (k < 5 || (k >= 15 && k < 27)) ? 4'h2 : 4'h0;
      step(v);
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL delayed_glitch cyc=%0d got=%h exp=%h", k, obs, exp);
      end
    end
  endtask

  task automatic test_independence();
    logic [23:0] exp;
    logic [N-1:0] v;
    apply_reset();
    for (int k = 0; k < 50; k++) begin
      v = 4'h4;
      if (k < 30) v[3] = 1'($urandom_range(0, 1));
      else v[3] = 1'b1;
      step(v);
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL independence cyc=%0d got=%h exp=%h", k, obs, exp);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [23:0] exp;
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      step(4'h3);
      void'(exp_q.pop_front());
    end
    reset_n = 1'b0;
    model_reset();
    #1;
    exp = model_vec();
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL mid_reset_async got=%h exp=%h", obs, exp);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int k = 0; k < 24; k++) begin
      step(4'h3);
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL mid_reset_restart cyc=%0d got=%h exp=%h", k, obs, exp);
      end
    end
  endtask

  task automatic test_random();
    logic [23:0] exp;
    logic [N-1:0] v;
    apply_reset();
    v = '0;
    for (int k = 0; k < 800; k++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 7) == 0) v[i] = ~v[i];
      if ($urandom_range(0, 199) == 0) begin
        reset_n = 1'b0;
        model_reset();
        #1;
        exp = model_vec();
        checks++;
        if (obs !== exp) begin
          errors++;
          $display("FAIL random_reset cyc=%0d got=%h exp=%h", k, obs, exp);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
      end
      step(v);
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL random cyc=%0d in=%h got=%h exp=%h", k, v, obs, exp);
      end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_early_bounce();
    test_lockout_expiry();
    test_delayed_glitch();
    test_independence();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
